// File: rtl/ao_rad4_seq_mult.sv
// Sequential signed radix-4 Booth multiplier: one Booth digit per cycle.
// A per-transaction skip drops the K lowest digits, trading accuracy for latency.
module ao_rad4_seq_mult #(
    parameter int WIDTH = 16,
    parameter int SKW   = $clog2(WIDTH / 2)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       x,
    input  logic [WIDTH-1:0]       y,
    input  logic [SKW-1:0]         skip,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [2*WIDTH-1:0]     p,
    output logic                   busy
);
    localparam int N  = WIDTH / 2;
    localparam int IW = $clog2(N);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               state_reg, state_next;
    logic                 in_ready_reg;
    logic [WIDTH-1:0]     x_reg;
    logic [WIDTH:0]       y_ext_reg;       // y with the implicit y[-1] = 0 appended
    logic [IW-1:0]        idx_reg, idx_next;
    logic [2*WIDTH-1:0]   acc_reg, acc_next;

    logic                 accept;
    logic                 last_digit;
    logic [IW-1:0]        k_sat;
    logic [IW:0]          bit_pos;
    logic [2:0]           triplet;
    logic                 one, two, neg;
    logic [WIDTH:0]       mag;
    logic [WIDTH:0]       pp_inv;
    logic [2*WIDTH-1:0]   pp_ext;

    assign accept     = in_valid && in_ready_reg && (state_reg == S_IDLE);
    assign last_digit = (idx_reg == IW'(N - 1));
    assign k_sat      = (int'(skip) > N - 1) ? IW'(N - 1) : IW'(skip);

    // Booth recoding of the current digit into one/two/sign controls.
    assign bit_pos = {idx_reg, 1'b0};
    assign triplet = 3'(y_ext_reg >> bit_pos);
    assign one     = triplet[1] ^ triplet[0];
    assign two     = (triplet == 3'b100) || (triplet == 3'b011);
    assign neg     = triplet[2];

    always_comb begin
        mag = '0;
        if (two) begin
            mag = {x_reg, 1'b0};
        end else if (one) begin
            mag = {x_reg[WIDTH-1], x_reg};
        end
    end

    // Negate as invert-plus-one after sign extension so that -2*min(x) stays exact.
    assign pp_inv = mag ^ {(WIDTH + 1){neg}};
    assign pp_ext = {{(WIDTH - 1){pp_inv[WIDTH]}}, pp_inv} + (2 * WIDTH)'(neg);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        acc_next   = acc_reg;
        case (state_reg)
            S_IDLE: begin
                if (accept) begin
                    state_next = S_CALC;
                    idx_next   = k_sat;
                    acc_next   = '0;
                end
            end
            S_CALC: begin
                acc_next = acc_reg + (pp_ext << bit_pos);
                if (last_digit) begin
                    state_next = S_DONE;
                end else begin
                    idx_next = idx_reg + IW'(1);
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            in_ready_reg <= 1'b0;
            x_reg        <= '0;
            y_ext_reg    <= '0;
            idx_reg      <= '0;
            acc_reg      <= '0;
        end else begin
            in_ready_reg <= (state_next == S_IDLE);
            if (accept) begin
                x_reg     <= x;
                y_ext_reg <= {y, 1'b0};
            end
            idx_reg <= idx_next;
            acc_reg <= acc_next;
        end
    end

    always_comb begin
        out_valid = (state_reg == S_DONE);
        busy      = (state_reg != S_IDLE);
    end

    assign in_ready = in_ready_reg;
    assign p        = acc_reg;

endmodule

// File: tb/tb_ao_rad4_seq_mult.sv
// Scoreboard bench for ao_rad4_seq_mult at WIDTH 8, 12 and 16 sharing one clock and reset.
module tb_ao_rad4_seq_mult;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        in_valid_a [3];
    logic        out_ready_a[3];
    logic        in_ready_a [3];
    logic        out_valid_a[3];
    logic        busy_a     [3];
    logic [15:0] x_a        [3];
    logic [15:0] y_a        [3];
    logic [2:0]  skip_a     [3];
    logic [31:0] p_a        [3];

    int     n_checks = 0;
    int     n_pass   = 0;
    longint exp_q[$];
    int     lat_q[$];
    time    accept_t;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_dut
            localparam int W = 8 + 4 * gi;
            localparam int S = $clog2(W / 2);
            logic [2*W-1:0] p_w;
            logic           ir, ov, bz;
            ao_rad4_seq_mult #(.WIDTH(W)) u_dut (
                .clk       (clk),
                .rst_n     (rst_n),
                .in_valid  (in_valid_a[gi]),
                .in_ready  (ir),
                .x         (x_a[gi][W-1:0]),
                .y         (y_a[gi][W-1:0]),
                .skip      (skip_a[gi][S-1:0]),
                .out_valid (ov),
                .out_ready (out_ready_a[gi]),
                .p         (p_w),
                .busy      (bz)
            );
            assign in_ready_a[gi]  = ir;
            assign out_valid_a[gi] = ov;
            assign busy_a[gi]      = bz;
            assign p_a[gi]         = 32'($signed(p_w));
        end
    endgenerate

    // Closed form: x times y rounded half-up to a multiple of 4^k.
    function automatic longint golden(input int w, input logic [15:0] xv,
                                      input logic [15:0] yv, input int k);
        longint msk, xs, ys, yr;
        msk = (longint'(1) << w) - 1;
        xs  = longint'(xv) & msk;
        ys  = longint'(yv) & msk;
        if (xs >= (longint'(1) << (w - 1))) xs = xs - (longint'(1) << w);
        if (ys >= (longint'(1) << (w - 1))) ys = ys - (longint'(1) << w);
        if (k == 0) return xs * ys;
        yr = (ys >>> (2 * k)) + longint'(yv[2*k-1]);
        return xs * (yr << (2 * k));
    endfunction

    task automatic run_txn(input int sel, input logic [15:0] xv, input logic [15:0] yv,
                           input logic [2:0] sk, input int stall, input string tag);
        int w, n, skw, k, d, cnt, guard, exp_lat;
        logic [31:0] exp_p;
        w   = 8 + 4 * sel;
        n   = w / 2;
        skw = $clog2(n);
        k   = int'(sk) & ((1 << skw) - 1);
        if (k > n - 1) k = n - 1;
        d = n - k;
        exp_q.push_back(golden(w, xv, yv, k));
        lat_q.push_back(d + 1);
        x_a[sel] = xv; y_a[sel] = yv; skip_a[sel] = sk;
        in_valid_a[sel]  = 1'b1;
        out_ready_a[sel] = 1'b0;
        guard = 0;
        while (in_ready_a[sel] !== 1'b1 && guard < 50) begin
            @(posedge clk); #1; guard++;
        end
        if (guard >= 50) begin
            n_checks++;
            $display("FAIL accept_timeout %s: in_ready=%b required 1", tag, in_ready_a[sel]);
            void'(exp_q.pop_front());
            void'(lat_q.pop_front());
            in_valid_a[sel] = 1'b0;
            return;
        end
        @(posedge clk);
        accept_t = $time;
        #1;
        in_valid_a[sel] = 1'b0;
        x_a[sel] = 16'($urandom); y_a[sel] = 16'($urandom); skip_a[sel] = 3'($urandom);
        cnt = 1;
        while (out_valid_a[sel] !== 1'b1 && cnt < 40) begin
            in_valid_a[sel] = 1'($urandom_range(0, 1));
            @(posedge clk); #1; cnt++;
        end
        in_valid_a[sel] = 1'b0;
        exp_p   = 32'(exp_q.pop_front());
        exp_lat = lat_q.pop_front();
        n_checks++;
        if (cnt !== exp_lat) $display("FAIL latency %s: got %0d required %0d", tag, cnt, exp_lat);
        else n_pass++;
        n_checks++;
        if (p_a[sel] !== exp_p) $display("FAIL product %s w=%0d x=%h y=%h k=%0d: got %h required %h",
                                         tag, w, xv, yv, k, p_a[sel], exp_p);
        else n_pass++;
        for (int s = 0; s < stall; s++) begin
            in_valid_a[sel] = (s == 1);
            @(posedge clk); #1;
            n_checks++;
            if (out_valid_a[sel] !== 1'b1 || in_ready_a[sel] !== 1'b0 || p_a[sel] !== exp_p)
                $display("FAIL stall %s: out_valid=%b in_ready=%b p=%h required 1 0 %h",
                         tag, out_valid_a[sel], in_ready_a[sel], p_a[sel], exp_p);
            else n_pass++;
        end
        in_valid_a[sel]  = 1'b0;
        out_ready_a[sel] = 1'b1;
        @(posedge clk); #1;
        out_ready_a[sel] = 1'b0;
        n_checks++;
        if (out_valid_a[sel] !== 1'b0 || in_ready_a[sel] !== 1'b1 || busy_a[sel] !== 1'b0)
            $display("FAIL complete %s: out_valid=%b in_ready=%b busy=%b required 0 1 0",
                     tag, out_valid_a[sel], in_ready_a[sel], busy_a[sel]);
        else n_pass++;
        $display("txn %s w=%0d x=%h y=%h k=%0d p=%h lat=%0d", tag, w, xv, yv, k, p_a[sel], cnt);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int s = 0; s < 3; s++) begin
            in_valid_a[s] = 1'b0; out_ready_a[s] = 1'b0;
            x_a[s] = '0; y_a[s] = '0; skip_a[s] = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int s = 0; s < 3; s++) begin
            n_checks++;
            if (in_ready_a[s] !== 1'b0 || out_valid_a[s] !== 1'b0 || busy_a[s] !== 1'b0 || p_a[s] !== 32'h0)
                $display("FAIL reset_state dut%0d: in_ready=%b out_valid=%b busy=%b p=%h required 0 0 0 0",
                         s, in_ready_a[s], out_valid_a[s], busy_a[s], p_a[s]);
            else n_pass++;
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        for (int s = 0; s < 3; s++) begin
            n_checks++;
            if (in_ready_a[s] !== 1'b1)
                $display("FAIL reset_release dut%0d: in_ready=%b required 1", s, in_ready_a[s]);
            else n_pass++;
        end
    endtask

    task automatic test_exact_corner();
        run_txn(2, 16'h8000, 16'h8000, 3'd0, 0, "corner");
    endtask

    task automatic test_approx();
        run_txn(2, 16'd1000, 16'd1234, 3'd1, 2, "approx");
    endtask

    task automatic test_max_skip();
        run_txn(2, 16'd3, 16'h7FFF, 3'd7, 0, "maxskip_hi");
        run_txn(2, 16'd3, 16'h1FFF, 3'd7, 0, "maxskip_lo");
        run_txn(1, 16'h0ABC, 16'h0FED, 3'd7, 1, "sat12");
    endtask

    task automatic test_backpressure();
        time t_done;
        run_txn(2, 16'h1234, 16'hF00D, 3'd2, 5, "backpressure");
        t_done = $time;
        run_txn(2, 16'h7FFF, 16'h7FFF, 3'd0, 0, "after_bp");
        n_checks++;
        if (accept_t !== t_done + 9)
            $display("FAIL reaccept_time: got %0t required %0t", accept_t, t_done + 9);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        time t_first;
        run_txn(2, 16'h0101, 16'hFF00, 3'd0, 0, "b2b_a");
        t_first = accept_t;
        run_txn(2, 16'h8001, 16'h00FF, 3'd0, 0, "b2b_b");
        n_checks++;
        if (accept_t - t_first !== 100)
            $display("FAIL throughput: got %0t required 100", accept_t - t_first);
        else n_pass++;
    endtask

    task automatic test_reset_abort();
        x_a[2] = 16'd100; y_a[2] = 16'd200; skip_a[2] = 3'd0;
        in_valid_a[2] = 1'b1;
        @(posedge clk); #1;
        in_valid_a[2] = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        n_checks++;
        if (out_valid_a[2] !== 1'b0 || busy_a[2] !== 1'b0 || p_a[2] !== 32'h0 || in_ready_a[2] !== 1'b0)
            $display("FAIL abort_state: out_valid=%b busy=%b p=%h in_ready=%b required 0 0 0 0",
                     out_valid_a[2], busy_a[2], p_a[2], in_ready_a[2]);
        else n_pass++;
        @(posedge clk); #1;
        n_checks++;
        if (in_ready_a[2] !== 1'b1 || out_valid_a[2] !== 1'b0)
            $display("FAIL abort_release: in_ready=%b out_valid=%b required 1 0", in_ready_a[2], out_valid_a[2]);
        else n_pass++;
        run_txn(2, 16'hFFF9, 16'd5, 3'd0, 0, "after_abort");
    endtask

    task automatic test_random();
        for (int s = 0; s < 3; s++) begin
            for (int i = 0; i < 800; i++) begin
                run_txn(s, 16'($urandom), 16'($urandom), 3'($urandom_range(0, 7)),
                        $urandom_range(0, 3), "rand");
            end
        end
    endtask

    initial begin
        test_reset();
        test_exact_corner();
        test_approx();
        test_max_skip();
        test_backpressure();
        test_back_to_back();
        test_reset_abort();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
